// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store sequencer.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ1,
        S_WAIT1,
        S_REQ2,
        S_WAIT2,
        S_RESP
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Byte mask spans two words so a misaligned access can spill into the next one.
    localparam int BEAT_MASK_W = 8;

    function automatic logic [2:0] size_bytes(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and extends load data from the one or two captured memory words.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] beat1,
    input  logic [31:0] beat2,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = 32'({beat2, beat1} >> {off, 3'b000});

    always_comb begin
        rdata = '0;
        case (funct3)
            F3_LB:   rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   rdata = shifted;
            F3_LBU:  rdata = {24'd0, shifted[7:0]};
            F3_LHU:  rdata = {16'd0, shifted[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer: one outstanding access, misaligned accesses split into two word beats.
//   state   | meaning
//   S_IDLE  | ready for a new request
//   S_REQ1  | first beat requested, waiting for grant
//   S_WAIT1 | first beat granted, waiting for rvalid
//   S_REQ2  | second beat requested, waiting for grant
//   S_WAIT2 | second beat granted, waiting for rvalid
//   S_RESP  | one-cycle response to writeback
module lsu_controller
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              busy
);

    lsu_state_e state_q, state_d;

    logic              ready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic [31:0]       beat1_q;
    logic [31:0]       beat2_q;
    logic              store_q;
    logic              err_q;

    logic                   req_legal;
    logic                   accept;
    logic [1:0]             off;
    logic [2:0]             size;
    logic [BEAT_MASK_W-1:0] base_mask;
    logic [BEAT_MASK_W-1:0] mask;
    logic                   split;
    logic [63:0]            wd64;
    logic [ADDR_W-1:0]      word_addr;
    logic [31:0]            load_data;

    always_comb begin
        req_legal = 1'b0;
        if (req_load && !req_store)
            req_legal = req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        else if (req_store && !req_load)
            req_legal = req_funct3 inside {F3_SB, F3_SH, F3_SW};
    end

    assign accept = (state_q == S_IDLE) && ready_q && req_valid;

    assign off  = addr_q[1:0];
    assign size = size_bytes(f3_q[1:0]);

    always_comb begin
        case (size)
            3'd1:    base_mask = 8'h01;
            3'd2:    base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
    end

    assign mask      = base_mask << off;
    assign split     = (({1'b0, off} + size) > 3'd4);
    assign wd64      = {32'd0, wdata_q} << {off, 3'b000};
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    lsu_load_align u_load_align (
        .beat1  (beat1_q),
        .beat2  (beat2_q),
        .off    (off),
        .funct3 (f3_q),
        .rdata  (load_data)
    );

    // ready_q is low during and just after reset so every output reads 0 under reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            beat1_q <= '0;
            beat2_q <= '0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
            if (accept) begin
                addr_q  <= req_addr;
                f3_q    <= req_funct3;
                wdata_q <= req_wdata;
                store_q <= req_store;
                err_q   <= !req_legal;
                beat1_q <= '0;
                beat2_q <= '0;
            end
            if (state_q == S_WAIT1 && mem_rvalid)
                beat1_q <= mem_rdata;
            if (state_q == S_WAIT2 && mem_rvalid)
                beat2_q <= mem_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        busy      = (state_q != S_IDLE);
        req_ready = ready_q;

        case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = req_legal ? S_REQ1 : S_RESP;
            end
            S_REQ1: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_be    = mask[3:0];
                mem_addr  = word_addr;
                mem_wdata = store_q ? wd64[31:0] : 32'd0;
                if (mem_gnt)
                    state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (mem_rvalid)
                    state_d = split ? S_REQ2 : S_RESP;
            end
            S_REQ2: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_be    = mask[7:4];
                mem_addr  = word_addr + ADDR_W'(4);
                mem_wdata = store_q ? wd64[63:32] : 32'd0;
                if (mem_gnt)
                    state_d = S_WAIT2;
            end
            S_WAIT2: begin
                if (mem_rvalid)
                    state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || store_q) ? 32'd0 : load_data;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/lsu_controller.md
# lsu_controller

Load/store sequencer between the core's memory stage and a word-wide data memory port. Accepts one load or store per request and generates byte enables and lane-shifted write data. Splits misaligned accesses into two word beats and runs a one-outstanding request/grant/response handshake. Returns sign- or zero-extended load data to writeback.

## Interface
- ADDR_W, 32, byte-address width of `req_addr` and `mem_addr`.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_load / req_store  in  1 each  access type. Both low or both high is illegal.
- req_funct3  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- mem_req  out  1  memory request; held until `mem_gnt`.
- mem_we  out  1  1 = write beat.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] always 0.
- mem_wdata  out  32  lane-aligned write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  beat complete; read data valid for loads, ack for stores.
- mem_rdata  in  32  read data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  qualifies `rsp_valid`; illegal request, no memory access made.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
- IDLE: `req_valid` is accepted; request fields are registered.
  - Illegal type or funct3 → RESP with error set.
  - Otherwise → REQ1.
- Size: byte = 1, half = 2, word = 4. Offset `off` = `addr[1:0]`. Beat mask `m` = ((1<<size)-1) << off, 8 bits wide.
- Two-beat condition: `off + size > 4`. Beat 1 uses `m[3:0]` at word address A. Beat 2 uses `m[7:4]` at A+4, with wrap modulo 2^ADDR_W.
- Store data: `wdata` zero-extended to 64 bits, shifted left by 8·off. Beat 1 drives bits [31:0]; beat 2 drives bits [63:32].
- REQ*: `mem_req`=1. `mem_addr`, `mem_be`, `mem_we`, `mem_wdata` are stable until `mem_gnt`. On `mem_gnt` → WAIT*.
- WAIT*: on `mem_rvalid`, capture `mem_rdata` into the beat-1 or beat-2 register. Then go to REQ2 if split and in WAIT1, else RESP.
- Load result: {beat2, beat1} >> 8·off, low `size` bytes taken. Sign-extend for 000/001, zero-extend for 100/101, pass through for 010.
- RESP: `rsp_valid`=1 for one cycle → IDLE.
- `mem_rvalid` outside WAIT* is ignored. `mem_gnt` outside REQ* is ignored.
- Reset value of every output is 0, state is IDLE, and all registers are cleared. This holds mid-transaction: the in-flight access is abandoned and no response is issued.

## Timing
- Accept at cycle T; `mem_req` rises at T+1.
- Aligned access with grant at T+1 and rvalid at T+2: `rsp_valid` at T+3.
- Split access, zero-wait memory: `rsp_valid` at T+5.
- Illegal request: `rsp_valid`/`rsp_err` at T+1.
- Earliest next accept: the cycle after RESP.
- `mem_rvalid` in the same cycle as `mem_gnt` is not a completion. The earliest legal rvalid is the cycle after grant.
- Outputs are registered or decoded from state and registered fields only. There is no combinational path from `mem_*` inputs to `mem_*` outputs.

## Structure
- Package `lsu_pkg` holds:
  - state encoding;
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW;
  - size decode function;
  - beat-mask width constant.
- Sub-module `lsu_load_align` is combinational. Inputs: beat1, beat2, off, funct3. Output: `rsp_rdata` before registering.
- The FSM, field registers, byte-enable and store-shift logic live in `lsu_controller`.

## Test plan
- LB at 0x103, rdata 0x80FF1234 → `mem_addr` 0x100, `mem_be` 1000, `rsp_rdata` 0xFFFFFF80. The same access as LBU → 0x00000080.
- LH at 0x203 (split): beat 1 at 0x200, be 1000, rdata 0xAB000000; beat 2 at 0x204, be 0001, rdata 0x000000CD → `rsp_rdata` 0xFFFFCDAB. With zero-wait memory, `rsp_valid` at T+5.
- SB at 0x102, wdata 0x00000055 → one beat: `mem_we`=1, addr 0x100, be 0100, `mem_wdata` 0x00550000, `rsp_rdata` 0.
- SW at 0x101, wdata 0x11223344 → beat 1: 0x100, be 1110, wdata 0x22334400. Beat 2: 0x104, be 0001, wdata 0x00000011.
- Grant withheld for 3 cycles in REQ1 → `mem_addr`/`mem_be`/`mem_wdata` stay constant and `req_ready` stays 0. A stray `mem_rvalid` during REQ1 changes nothing.
- Load with funct3 011 → no `mem_req`; `rsp_valid` and `rsp_err` pulse at T+1.
- Reset asserted in WAIT1 → all outputs 0 immediately and state IDLE. A late `mem_rvalid` after reset produces no `rsp_valid`.
